alu_control_unit: RTL and testbench

- Sequencing FSM that drives the `c0`–`c7` control lines of `arithmetic_unit` and consumes its status flags (`cnt_done`, `q0`, `qm1`, `a7`).
- Runs operand loading, the single-pass add/sub, radix-2 Booth multiply, non-restoring divide, and result hand-off through a start/done/ack handshake.
- Sits between the ALU top-level request logic and the datapath; it holds no arithmetic state of its own.

---
 rtl/alu_ctrl_pkg.sv | 23 ++
 rtl/alu_control_unit.sv | 170 +++++++++++++++++
 tb/tb_alu_control_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU sequencing controller.
//   state_t : the nine controller states
//   OP_*    : two-bit operation encodings carried on op / op_q
package alu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE        = 4'd0,
        ST_LOAD_M      = 4'd1,
        ST_LOAD_Q      = 4'd2,
        ST_BOOTH_ADD   = 4'd3,
        ST_BOOTH_SHIFT = 4'd4,
        ST_DIV_SHIFT   = 4'd5,
        ST_DIV_ADDSUB  = 4'd6,
        ST_DIV_CORR    = 4'd7,
        ST_RESULT      = 4'd8
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/alu_control_unit.sv
// Sequencing controller for arithmetic_unit: operand load, add/sub,
// radix-2 Booth multiply, non-restoring divide, start/done/ack hand-off.
// Ports:
//   clk, rst (async active-low)
//   start, op[1:0]      request and operation, taken in IDLE only
//   ack                 result consumed, taken in RESULT only
//   cnt_done,q0,qm1,a7  datapath status
//   op_q[1:0]           captured operation, drives datapath op
//   c0..c7              datapath controls
//   busy, done          handshake status
// Outputs are decodes of the state register; c2, c3 and c6 additionally
// depend on the status inputs within the Booth/divide states.
module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       ack,
    input  logic       cnt_done,
    input  logic       q0,
    input  logic       qm1,
    input  logic       a7,
    output logic [1:0] op_q,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c4,
    output logic       c5,
    output logic       c6,
    output logic       c7,
    output logic       busy,
    output logic       done
);

    state_t state_r;
    state_t state_nxt_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operation capture: only an accepted start updates op_q, so later op
    // changes cannot disturb a running sequence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q <= OP_ADD;
        end else if ((state_r == ST_IDLE) && start) begin
            op_q <= op;
        end else begin
            op_q <= op_q;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt_s = state_r;
        c0   = 1'b0;
        c1   = 1'b0;
        c2   = 1'b0;
        c3   = 1'b0;
        c4   = 1'b0;
        c5   = 1'b0;
        c6   = 1'b0;
        c7   = 1'b0;
        busy = 1'b1;
        done = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt_s = ST_LOAD_M;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD_M: begin
                // c0 also clears the datapath iteration counter.
                c0          = 1'b1;
                state_nxt_s = ST_LOAD_Q;
            end
            ST_LOAD_Q: begin
                c1 = 1'b1;
                if (!op_q[1]) begin
                    state_nxt_s = ST_RESULT;
                end else if (op_q[0]) begin
                    state_nxt_s = ST_DIV_SHIFT;
                end else begin
                    state_nxt_s = ST_BOOTH_ADD;
                end
            end
            ST_BOOTH_ADD: begin
                // Booth pair 10: subtract M; 01: add M; 00/11: no operation.
                if (q0 && !qm1) begin
                    c2 = 1'b1;
                    c3 = 1'b1;
                end else if (!q0 && qm1) begin
                    c2 = 1'b1;
                    c3 = 1'b0;
                end else begin
                    c2 = 1'b0;
                    c3 = 1'b0;
                end
                state_nxt_s = ST_BOOTH_SHIFT;
            end
            ST_BOOTH_SHIFT: begin
                // Arithmetic right shift: sign bit refills the top.
                c4 = 1'b1;
                c5 = 1'b1;
                c6 = a7;
                if (cnt_done) begin
                    state_nxt_s = ST_RESULT;
                end else begin
                    state_nxt_s = ST_BOOTH_ADD;
                end
            end
            ST_DIV_SHIFT: begin
                // Quotient bit is the inverse of the current remainder sign.
                c4          = 1'b1;
                c5          = 1'b1;
                c6          = ~a7;
                state_nxt_s = ST_DIV_ADDSUB;
            end
            ST_DIV_ADDSUB: begin
                // Subtract while the remainder is non-negative, else add back.
                c2 = 1'b1;
                c3 = ~a7;
                if (cnt_done) begin
                    state_nxt_s = ST_DIV_CORR;
                end else begin
                    state_nxt_s = ST_DIV_SHIFT;
                end
            end
            ST_DIV_CORR: begin
                // Negative final remainder gets one restoring add.
                if (a7) begin
                    c2 = 1'b1;
                    c3 = 1'b0;
                end else begin
                    c2 = 1'b0;
                    c3 = 1'b0;
                end
                state_nxt_s = ST_RESULT;
            end
            ST_RESULT: begin
                done = 1'b1;
                // Add/sub result is combinational in the datapath; only
                // mul/div need the result register strobe.
                c7 = op_q[1];
                if (ack) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: begin
                busy        = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit. A timeline model (cycles since the
// accepted start) predicts every output each cycle; literal checks at
// chosen cycles pin the model against hand-computed values.
module tb_alu_control_unit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       ack;
    logic       cnt_done;
    logic       q0;
    logic       qm1;
    logic       a7;
    logic [1:0] op_q;
    logic       c0, c1, c2, c3, c4, c5, c6, c7;
    logic       busy;
    logic       done;

    logic [11:0] outvec;

    int errors;
    int checks;

    // Model state
    logic       m_active;
    int         m_k;
    logic [1:0] m_op;
    logic [1:0] m_opq;

    alu_control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .ack      (ack),
        .cnt_done (cnt_done),
        .q0       (q0),
        .qm1      (qm1),
        .a7       (a7),
        .op_q     (op_q),
        .c0       (c0),
        .c1       (c1),
        .c2       (c2),
        .c3       (c3),
        .c4       (c4),
        .c5       (c5),
        .c6       (c6),
        .c7       (c7),
        .busy     (busy),
        .done     (done)
    );

    assign outvec = {op_q, c0, c1, c2, c3, c4, c5, c6, c7, busy, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int result_cycle(input logic [1:0] o);
        if (!o[1]) return 3;
        else if (o[0]) return 20;
        else return 19;
    endfunction

    // Expected outputs from the position in the operation timeline.
    function automatic logic [11:0] model_out(input logic act, input int k,
                                              input logic [1:0] mop, input logic [1:0] mopq,
                                              input logic iq0, input logic iqm1, input logic ia7);
        logic [7:0] c;
        logic       d;
        int         rk;
        c  = 8'h00;
        d  = 1'b0;
        rk = result_cycle(mop);
        if (act) begin
            if (k == 1) c[0] = 1'b1;
            else if (k == 2) c[1] = 1'b1;
            else if (k >= rk) begin
                d    = 1'b1;
                c[7] = mop[1];
            end else if (mop == 2'b10) begin
                if ((k % 2) == 1) begin
                    if (iq0 != iqm1) begin
                        c[2] = 1'b1;
                        c[3] = iq0;
                    end
                end else begin
                    c[4] = 1'b1;
                    c[5] = 1'b1;
                    c[6] = ia7;
                end
            end else begin
                if (k == 19) c[2] = ia7;
                else if ((k % 2) == 1) begin
                    c[4] = 1'b1;
                    c[5] = 1'b1;
                    c[6] = ~ia7;
                end else begin
                    c[2] = 1'b1;
                    c[3] = ~ia7;
                end
            end
        end
        return {mopq, c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], act, d};
    endfunction

    // Model timeline update.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_op     <= 2'b00;
            m_opq    <= 2'b00;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_op     <= op;
                m_opq    <= op;
            end
        end else if (m_k >= result_cycle(m_op)) begin
            if (ack) m_active <= 1'b0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [11:0] exp_v;
        exp_v  = model_out(m_active, m_k, m_op, m_opq, q0, qm1, a7);
        checks = checks + 1;
        if (outvec !== exp_v) begin
            errors = errors + 1;
            $display("FAIL cycle_model t=%0t got=%b expected=%b", $time, outvec, exp_v);
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp_v);
        checks = checks + 1;
        if (act !== exp_v) begin
            errors = errors + 1;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp_v);
        end
    endtask

    function automatic logic [2:0] pat(input int cyc, input logic corr_a7);
        logic [2:0] v;
        case (cyc)
            3:       v = 3'b101;
            4:       v = 3'b001;
            5:       v = 3'b010;
            6:       v = 3'b000;
            7:       v = 3'b110;
            19:      v = {2'b00, corr_a7};
            default: v = 3'((cyc * 3 + 1) % 8);
        endcase
        return v;
    endfunction

    // One operation from start to ack (or to an aborting reset).
    task automatic run_op(input logic [1:0] op_v, input int hold, input logic corr_a7,
                          input int abort_at, input logic sw_op, input logic spam);
        int res_k;
        res_k = result_cycle(op_v);
        start = 1'b1;
        op    = op_v;
        ack   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        if (sw_op) op = 2'b00;
        for (int cyc = 1; cyc < res_k; cyc++) begin
            {q0, qm1, a7} = pat(cyc, corr_a7);
            cnt_done = (cyc == 17) || (cyc == 18);
            start    = spam && (cyc >= 4) && (cyc <= 15);
            ack      = spam && ((cyc == 2) || (cyc == 9));
            if (cyc == abort_at) begin
                #2 rst = 1'b0;
                #1;
                chk("reset_async", outvec, 12'h000);
                @(posedge clk); #1;
                rst   = 1'b1;
                start = 1'b0;
                ack   = 1'b0;
                @(negedge clk);
                chk("reset_idle", {10'd0, busy, done}, 12'h000);
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            if (cyc == 1) chk("load_m_c0", {11'd0, c0}, 12'd1);
            if (cyc == 2) chk("load_q_c1", {11'd0, c1}, 12'd1);
            if (cyc == res_k - 1) chk("done_early", {11'd0, done}, 12'd0);
            if (op_v == 2'b10) begin
                if (cyc == 3) chk("booth_10", {10'd0, c2, c3}, 12'b11);
                if (cyc == 4) chk("booth_shift_a7_1", {9'd0, c4, c5, c6}, 12'b111);
                if (cyc == 5) chk("booth_01", {10'd0, c2, c3}, 12'b10);
                if (cyc == 6) chk("booth_shift_a7_0", {9'd0, c4, c5, c6}, 12'b110);
                if (cyc == 7) chk("booth_11", {11'd0, c2}, 12'd0);
            end
            if (op_v == 2'b11) begin
                if (cyc == 3) chk("div_shift_a7_1", {11'd0, c6}, 12'd0);
                if (cyc == 4) chk("div_addsub_a7_1", {10'd0, c2, c3}, 12'b10);
                if (cyc == 5) chk("div_shift_a7_0", {11'd0, c6}, 12'd1);
                if (cyc == 6) chk("div_addsub_a7_0", {10'd0, c2, c3}, 12'b11);
                if (cyc == 19) chk("div_corr", {10'd0, c2, c3}, {10'd0, corr_a7, 1'b0});
            end
            @(posedge clk); #1;
        end
        start    = 1'b0;
        ack      = 1'b0;
        cnt_done = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk("result_hold", {7'd0, done, c7, busy, op_q},
                {7'd0, 1'b1, op_v[1], 1'b1, op_v});
            @(posedge clk); #1;
        end
        // start together with ack must not launch a new operation.
        ack   = 1'b1;
        start = spam;
        @(posedge clk); #1;
        ack   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("ack_idle", {10'd0, busy, done}, 12'h000);
        @(posedge clk); #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        ack      = 1'b0;
        cnt_done = 1'b0;
        q0       = 1'b0;
        qm1      = 1'b0;
        a7       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", outvec, 12'h000);
        @(posedge clk); #1;
        rst = 1'b1;
        // ack in IDLE is ignored
        ack = 1'b1;
        @(posedge clk); #1;
        ack = 1'b0;
        @(posedge clk); #1;

        run_op(2'b00, 0, 1'b0, 0, 1'b0, 1'b0);   // add
        run_op(2'b01, 2, 1'b0, 0, 1'b0, 1'b0);   // sub
        run_op(2'b10, 5, 1'b0, 0, 1'b0, 1'b1);   // mul, start/ack spam, long hold
        run_op(2'b11, 1, 1'b1, 0, 1'b0, 1'b0);   // div, negative remainder
        run_op(2'b11, 5, 1'b0, 0, 1'b0, 1'b1);   // div, non-negative remainder
        run_op(2'b10, 0, 1'b0, 0, 1'b1, 1'b0);   // mul with op switched after accept
        run_op(2'b10, 0, 1'b0, 10, 1'b0, 1'b0);  // mul aborted by reset
        run_op(2'b01, 0, 1'b0, 0, 1'b0, 1'b0);   // sub after abort

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
